// File: rtl/eggtimer_pkg.sv
// eggtimer_pkg: shared states, key codes and BCD constants for the egg timer front end
package eggtimer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_START     = 4'hB;
    localparam logic [3:0] KEY_STOP      = 4'hC;

    localparam logic [15:0] BCD_ZERO     = 16'h0000;
    localparam logic [3:0]  SEC_TENS_MAX = 4'h5;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider that pulses tick for one cycle every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] TERM = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;
    logic         term;

    // advance while enabled, wrap at terminal count, hold otherwise
    always_comb begin
        term   = en && cnt_q == TERM;
        cnt_d  = clr ? '0 : term ? '0 : en ? cnt_q + W'(1) : cnt_q;
        tick_d = term && !clr;
    end

    // count and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad MM:SS entry, countdown load strobe and decrement pacing for the egg timer
module time_entry_ctrl
    import eggtimer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] cur_time,
    output logic [15:0] mins_secs_out,
    output logic        wrt_en,
    output logic        dec_en,
    output logic        running,
    output logic        done,
    output logic        entry_err,
    output logic [2:0]  digit_count
);

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        wrt_q, run_q, done_q;
    logic        is_digit, is_clear, is_start, is_stop, at_zero, pre_en, tick;

    assign is_digit = key_valid && key_code <= KEY_DIGIT_MAX;
    assign is_clear = key_valid && key_code == KEY_CLEAR;
    assign is_start = key_valid && key_code == KEY_START;
    assign is_stop  = key_valid && key_code == KEY_STOP;
    assign at_zero  = cur_time == BCD_ZERO;

    // zero detection and STOP both beat a pending terminal count, so neither advances the divider
    assign pre_en = state_q == S_RUN && !at_zero && !is_stop;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == S_LOAD),
        .en    (pre_en),
        .tick  (tick)
    );

    // next-state, entry buffer and error flag
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (is_digit && cnt_q < 3'd4) begin
                    entry_d = {entry_q[11:0], key_code};
                    cnt_d   = cnt_q + 3'd1;
                    err_d   = 1'b0;
                end else if (is_clear) begin
                    entry_d = BCD_ZERO;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (is_start && entry_q != BCD_ZERO) begin
                    if (entry_q[7:4] > SEC_TENS_MAX) err_d = 1'b1;
                    else state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_RUN;
            S_RUN:   state_d = at_zero ? S_DONE : is_stop ? S_PAUSE : S_RUN;
            S_PAUSE: begin
                if (is_start) begin
                    state_d = S_RUN;
                end else if (is_clear) begin
                    entry_d = BCD_ZERO;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                if (is_start) begin
                    state_d = S_LOAD;
                end else if (is_clear) begin
                    entry_d = BCD_ZERO;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and registered status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            entry_q <= BCD_ZERO;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wrt_q   <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wrt_q   <= state_d == S_LOAD;
            run_q   <= state_d == S_RUN;
            done_q  <= state_d == S_DONE;
        end
    end

    assign mins_secs_out = entry_q;
    assign wrt_en        = wrt_q;
    assign dec_en        = tick;
    assign running       = run_q;
    assign done          = done_q;
    assign entry_err     = err_q;
    assign digit_count   = cnt_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: directed and random keypad traffic against a behavioural timer model
module tb_time_entry_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic        clk = 1'b0;
    logic        reset, key_valid;
    logic [3:0]  key_code;
    logic [15:0] cur_time, mins_secs_out;
    logic        wrt_en, dec_en, running, done, entry_err;
    logic [2:0]  digit_count;

    int errors = 0, checks = 0, dec_seen = 0;

    int          m_st = M_IDLE, m_cnt = 0, m_pre = 0;
    logic [15:0] m_buf = 16'h0;
    bit          m_err = 0, m_wrt = 0, m_dec = 0, m_run = 0, m_done = 0;

    time_entry_ctrl #(.TICK_DIV(TD)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .cur_time      (cur_time),
        .mins_secs_out (mins_secs_out),
        .wrt_en        (wrt_en),
        .dec_en        (dec_en),
        .running       (running),
        .done          (done),
        .entry_err     (entry_err),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // countdown register behaviour: MM:SS minus one second, via total seconds
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        int s;
        if (t == 16'h0) return 16'h0;
        s = int'(t[15:12]) * 600 + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]) - 1;
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic step(input bit rst, input bit kv, input logic [3:0] kc);
        int ns, nc, np;
        logic [15:0] nb, ncur;
        bit ne, nd, dig, clr, st, sp;
        reset = rst;
        key_valid = kv;
        key_code = kc;
        dig = kv && kc < 10;
        clr = kv && kc == 4'hA;
        st  = kv && kc == 4'hB;
        sp  = kv && kc == 4'hC;
        ncur = m_wrt ? m_buf : m_dec ? bcd_dec(cur_time) : cur_time;
        ns = m_st; nb = m_buf; nc = m_cnt; ne = m_err; np = m_pre; nd = 0;
        if (rst) begin
            ns = M_IDLE; nb = 0; nc = 0; ne = 0; np = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (dig) begin
                        if (m_cnt < 4) begin
                            nb = 16'((m_buf * 16 + kc) % 65536);
                            nc = m_cnt + 1;
                            ne = 0;
                        end
                    end else if (clr) begin
                        nb = 0; nc = 0; ne = 0;
                    end else if (st && m_buf != 0) begin
                        if (m_buf[7:4] > 5) ne = 1;
                        else ns = M_LOAD;
                    end
                end
                M_LOAD: begin
                    ns = M_RUN; np = 0;
                end
                M_RUN: begin
                    if (cur_time == 0) ns = M_DONE;
                    else if (sp) ns = M_PAUSE;
                    else if (m_pre == TD - 1) begin
                        nd = 1; np = 0;
                    end else np = m_pre + 1;
                end
                M_PAUSE: begin
                    if (st) ns = M_RUN;
                    else if (clr) begin
                        nb = 0; nc = 0; ns = M_LOAD;
                    end
                end
                default: begin
                    if (st) ns = M_LOAD;
                    else if (clr) begin
                        nb = 0; nc = 0; ne = 0; ns = M_IDLE;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        m_st = ns; m_buf = nb; m_cnt = nc; m_err = ne; m_pre = np; m_dec = nd;
        m_wrt = ns == M_LOAD;
        m_run = ns == M_RUN;
        m_done = ns == M_DONE;
        cur_time = ncur;
        dec_seen += int'(dec_en);
        check("wrt_en", wrt_en, m_wrt);
        check("dec_en", dec_en, m_dec);
        check("running", running, m_run);
        check("done", done, m_done);
        check("entry_err", entry_err, m_err);
        check("digit_count", digit_count, m_cnt[2:0]);
        check("mins_secs_out", mins_secs_out, m_buf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0);
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; cur_time = 16'h0;
        step(1, 0, 0);
        step(1, 0, 0);
        check("rst_out", mins_secs_out, 16'h0);
        check("rst_flags", {wrt_en, dec_en, running, done, entry_err}, 16'h0);
        check("rst_cnt", digit_count, 16'h0);

        // 1,3,0 then START; pause at prescaler count 2
        step(0, 1, 4'h1); step(0, 1, 4'h3); step(0, 1, 4'h0);
        check("buf_0130", mins_secs_out, 16'h0130);
        check("cnt_3", digit_count, 16'd3);
        step(0, 1, 4'hB);
        check("load_wrt", wrt_en, 1'b1);
        check("load_val", mins_secs_out, 16'h0130);
        step(0, 0, 0);
        check("run_hi", running, 1'b1);
        check("wrt_once", wrt_en, 1'b0);
        idle(2);
        step(0, 1, 4'hC);
        check("paused", running, 1'b0);
        dec_seen = 0;
        idle(10);
        check("pause_nodec", dec_seen, 16'd0);
        step(0, 1, 4'hB);
        step(0, 0, 0);
        check("resume_wait", dec_en, 1'b0);
        step(0, 0, 0);
        check("resume_dec", dec_en, 1'b1);

        // CLEAR from PAUSE loads zero and finishes; START in DONE reloads it
        step(0, 1, 4'hC);
        step(0, 1, 4'hA);
        check("clr_wrt", wrt_en, 1'b1);
        check("clr_val", mins_secs_out, 16'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("clr_done", done, 1'b1);
        step(0, 1, 4'hB);
        check("reload_wrt", wrt_en, 1'b1);
        check("reload_val", mins_secs_out, 16'h0);
        idle(2);
        check("reload_done", done, 1'b1);
        step(0, 1, 4'hA);
        check("done_clr", done, 1'b0);

        // 9,9,9,9,5: fifth digit dropped, START rejected
        step(0, 1, 4'h9); step(0, 1, 4'h9); step(0, 1, 4'h9); step(0, 1, 4'h9); step(0, 1, 4'h5);
        check("buf_9999", mins_secs_out, 16'h9999);
        check("cnt_4", digit_count, 16'd4);
        step(0, 1, 4'hB);
        check("err_set", entry_err, 1'b1);
        step(0, 0, 0);
        check("err_nowrt", wrt_en, 1'b0);
        check("err_norun", running, 1'b0);
        step(0, 1, 4'hA);
        check("err_clr", entry_err, 1'b0);
        check("buf_clr", mins_secs_out, 16'h0);

        // 00:02 runs down with exactly two decrements
        step(0, 1, 4'h2);
        step(0, 1, 4'hB);
        dec_seen = 0;
        for (int i = 0; i < 40 && !done; i++) step(0, 0, 0);
        check("run_done", done, 1'b1);
        check("run_decs", dec_seen, 16'd2);
        check("run_zero", cur_time, 16'h0);
        step(0, 1, 4'hA);

        // reset mid-run
        step(0, 1, 4'h1); step(0, 1, 4'h0); step(0, 1, 4'h0);
        step(0, 1, 4'hB);
        idle(6);
        step(1, 0, 0);
        check("mrst_out", mins_secs_out, 16'h0);
        check("mrst_flags", {wrt_en, dec_en, running, done, entry_err}, 16'h0);
        dec_seen = 0;
        idle(8);
        check("mrst_nodec", dec_seen, 16'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, kv;
            logic [3:0] kc;
            r  = $urandom_range(0, 199) == 0;
            kv = $urandom_range(0, 3) == 0;
            kc = $urandom_range(0, 1) ? 4'(4'hA + $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            step(r, kv, kc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_entry_ctrl.md
# time_entry_ctrl

Front-end controller for the egg timer: accepts BCD digit keystrokes, assembles an MM:SS value, validates it, and loads it into the BCD countdown register with a one-cycle write strobe. It then paces the countdown by issuing periodic decrement enables and watches the counter's returned value for zero. It sits between the keypad decoder and the countdown register, driving that register's write-enable, parallel-load and decrement-enable inputs.

## Interface
- TICK_DIV, 50_000_000, clk cycles per decrement tick (≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; clock clk
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0–9 digit, 0xA CLEAR, 0xB START, 0xC STOP, 0xD–0xF ignored
- cur_time  in  16  countdown register value {minTens,minOnes,secTens,secOnes}
- mins_secs_out  out  16  entry buffer, same packing; drives countdown parallel load
- wrt_en  out  1  one-cycle load strobe to countdown register
- dec_en  out  1  one-cycle decrement strobe
- running  out  1  high in RUN
- done  out  1  high in DONE
- entry_err  out  1  sticky invalid-entry flag
- digit_count  out  3  digits entered, 0–4

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - digit (digit_count<4) → buffer = {buffer[11:0], digit}, count+1, entry_err cleared.
  - digit at count 4 → dropped.
  - CLEAR → buffer 0, count 0, entry_err 0.
  - START with buffer==0 → ignored.
  - START with buffer[7:4]>5 → entry_err=1, stay in IDLE.
  - Any other START → LOAD.
  - STOP → ignored.
- LOAD: wrt_en=1 for exactly this cycle, mins_secs_out=buffer; prescaler cleared; next state RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; dec_en=1 in the cycle the count equals TICK_DIV-1, then wraps to 0.
  - cur_time==0 → DONE; dec_en suppressed that cycle.
  - STOP → PAUSE; prescaler holds its count; dec_en suppressed that cycle.
  - Digits, START and CLEAR are ignored.
- PAUSE:
  - START → RUN; prescaler resumes from its held count.
  - CLEAR → buffer 0, count 0, then LOAD, so zero is written to the counter and the state continues to RUN.
- DONE:
  - START → LOAD with the retained buffer (repeat the last time).
  - CLEAR → buffer 0, count 0, entry_err 0, then IDLE; no load issued.
  - Digits and STOP are ignored.
- CLEAR from PAUSE: the zero load reaches RUN, sees cur_time==0, and goes to DONE on the following cycle.
- The buffer is retained across runs; only CLEAR or reset zeroes it.
- No BCD range check on individual digits: keys 0–9 only.
- mins_secs_out is always the buffer.

## Timing
- All outputs are registered.
- Reset values: state IDLE, buffer/mins_secs_out 0, digit_count 0, wrt_en 0, dec_en 0, running 0, done 0, entry_err 0, prescaler 0.
- Key accepted at edge N: buffer and count updated after N.
- START accepted at edge N: wrt_en high in cycle N+1 (LOAD), running high from N+2.
- The counter loads at the edge ending LOAD, so cur_time is valid in the first RUN cycle.
- First dec_en occurs TICK_DIV cycles after entering RUN.
- Zero detection: cur_time==0 sampled in RUN → done high the next cycle.
- Zero and STOP in the same cycle: zero wins, go to DONE.
- Zero and prescaler terminal in the same cycle: no dec_en.
- Reset mid-operation: all outputs return to reset values at the next edge; no wrt_en issued.

## Structure
- Package eggtimer_pkg:
  - state enum
  - KEY_CLEAR/KEY_START/KEY_STOP constants
  - BCD_ZERO 16'h0000
  - SEC_TENS_MAX 4'h5
- Sub-module tick_prescaler:
  - parameter TICK_DIV
  - ports clk, reset, clr, en, tick
  - tick is a registered one-cycle pulse at terminal count; the count holds when en=0.

## Test plan
All scenarios use TICK_DIV=4 and a behavioural countdown model on cur_time.
- Keys 1,3,0 → mins_secs_out=16'h0130, digit_count=3. Then START → one wrt_en cycle with 16'h0130, running=1.
- Keys 9,9,9,9,5 → 5 dropped, buffer 16'h9999. Then START → entry_err=1, no wrt_en, state stays IDLE. Then CLEAR → entry_err=0, buffer 0.
- Load 16'h0002 → dec_en at RUN cycles 4 and 8; cur_time reaches 0; done=1 one cycle later; exactly 2 dec_en pulses total.
- STOP in RUN at prescaler count 2, hold 10 cycles → no dec_en. START → first dec_en 2 cycles after re-entering RUN.
- From PAUSE, CLEAR → wrt_en with 16'h0000, then done=1. From DONE, START → reload of 16'h0000 retained buffer.
- Assert reset during RUN mid-count → next cycle all outputs 0, state IDLE, no further dec_en.
